// File: rtl/strassen_pkg.sv
// Shared types and constants for the Strassen pre-add stream.
package strassen_pkg;

  // Product index k of the seven Strassen products; only 1..7 are used.
  typedef logic [2:0] prod_idx_t;

  localparam prod_idx_t K1 = 3'd1;
  localparam prod_idx_t K2 = 3'd2;
  localparam prod_idx_t K3 = 3'd3;
  localparam prod_idx_t K4 = 3'd4;
  localparam prod_idx_t K5 = 3'd5;
  localparam prod_idx_t K6 = 3'd6;
  localparam prod_idx_t K7 = 3'd7;

  // Quadrant positions inside a packed input row.
  localparam int Q11 = 0;
  localparam int Q12 = 1;
  localparam int Q21 = 2;
  localparam int Q22 = 3;

  // Stream controller states.
  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/strassen_operand_sel.sv
// One lane of the Strassen operand pre-adder: selects and combines the
// quadrant elements that form T_k and S_k for product k.
module strassen_operand_sel
  import strassen_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a11,
  input  logic [W-1:0] a12,
  input  logic [W-1:0] a21,
  input  logic [W-1:0] a22,
  input  logic [W-1:0] b11,
  input  logic [W-1:0] b12,
  input  logic [W-1:0] b21,
  input  logic [W-1:0] b22,
  input  logic [2:0]   idx,
  output logic [W:0]   t,
  output logic [W:0]   s
);

  // One extra bit holds any sum or difference of two W-bit values exactly.
  logic signed [W:0] xa11, xa12, xa21, xa22;
  logic signed [W:0] xb11, xb12, xb21, xb22;

  assign xa11 = {a11[W-1], a11};
  assign xa12 = {a12[W-1], a12};
  assign xa21 = {a21[W-1], a21};
  assign xa22 = {a22[W-1], a22};
  assign xb11 = {b11[W-1], b11};
  assign xb12 = {b12[W-1], b12};
  assign xb21 = {b21[W-1], b21};
  assign xb22 = {b22[W-1], b22};

  // Operand table for the seven products.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    t = '0;
    s = '0;
    case (prod_idx_t'(idx))
      K1: begin t = xa11 + xa22; s = xb11 + xb22; end
      K2: begin t = xa21 + xa22; s = xb11;        end
      K3: begin t = xa11;        s = xb12 - xb22; end
      K4: begin t = xa22;        s = xb21 - xb11; end
      K5: begin t = xa11 + xa12; s = xb22;        end
      K6: begin t = xa21 - xa11; s = xb11 + xb12; end
      K7: begin t = xa12 - xa22; s = xb21 + xb22; end
      default: begin t = '0; s = '0; end
    endcase
  end

endmodule

// File: rtl/strassen_preadd_stream.sv
// Accepts one row of A/B quadrants and streams the seven Strassen operand
// pairs (T_k, S_k) for that row, one per accepted output beat.
module strassen_preadd_stream
  import strassen_pkg::*;
#(
  parameter int W     = 8,
  parameter int LANES = 8,
  parameter int ROWS  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4*LANES*W-1:0]       in_a,
  input  logic [4*LANES*W-1:0]       in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*(W+1)-1:0]     out_t,
  output logic [LANES*(W+1)-1:0]     out_s,
  output logic [2:0]                 out_idx,
  output logic [$clog2(ROWS)-1:0]    out_row,
  output logic                       out_last
);

  localparam int              RW       = $clog2(ROWS);
  localparam int              QW       = LANES * W;
  localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);

  state_t                 state, state_next;
  prod_idx_t              idx;
  logic [RW-1:0]          row;
  logic [4*LANES*W-1:0]   buf_a, buf_b;
  logic                   accept, advance, row_done;

  assign accept   = in_valid && in_ready;
  assign advance  = out_valid && out_ready;
  assign row_done = advance && (idx == K7);

  // Next state and handshake outputs. in_ready in EMIT follows out_ready
  // combinationally so a new row can load on the k=7 beat with no bubble.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) state_next = EMIT;
        end
        EMIT: begin
          out_valid = 1'b1;
          in_ready  = (idx == K7) && out_ready;
          if ((idx == K7) && out_ready && !in_valid) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register, row buffer, product and row counters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state <= IDLE;
      idx   <= K1;
      row   <= '0;
      // NOTE: the row buffer is reset even though its contents are never
      // consumed before a load; this pins out_t/out_s to zero in reset.
      buf_a <= '0;
      buf_b <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        buf_a <= in_a;
        buf_b <= in_b;
        idx   <= K1;
      end else if (advance && (idx != K7)) begin
        idx <= idx + 3'd1;
      end
      if (row_done) row <= (row == ROW_LAST) ? '0 : row + 1'b1;
    end
  end

  assign out_idx  = idx;
  assign out_row  = row;
  assign out_last = out_valid && (idx == K7) && (row == ROW_LAST);

  // Lane datapath works only from the held row, never the live inputs.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    strassen_operand_sel #(.W(W)) u_sel (
      .a11 (buf_a[Q11*QW + i*W +: W]),
      .a12 (buf_a[Q12*QW + i*W +: W]),
      .a21 (buf_a[Q21*QW + i*W +: W]),
      .a22 (buf_a[Q22*QW + i*W +: W]),
      .b11 (buf_b[Q11*QW + i*W +: W]),
      .b12 (buf_b[Q12*QW + i*W +: W]),
      .b21 (buf_b[Q21*QW + i*W +: W]),
      .b22 (buf_b[Q22*QW + i*W +: W]),
      .idx (idx),
      .t   (out_t[i*(W+1) +: W+1]),
      .s   (out_s[i*(W+1) +: W+1])
    );
  end

endmodule

// File: tb/tb_strassen_preadd_stream.sv
// Scoreboard bench for strassen_preadd_stream: the driver pushes the seven
// expected beats of every accepted row; a monitor pops them on each output
// handshake.
module tb_strassen_preadd_stream;

  localparam int W     = 8;
  localparam int LANES = 8;
  localparam int ROWS  = 8;
  localparam int RW    = $clog2(ROWS);
  localparam int QW    = LANES * W;
  localparam int IW    = 4 * LANES * W;
  localparam int OW    = LANES * (W + 1);

  typedef struct packed {
    logic [OW-1:0] t;
    logic [OW-1:0] s;
    logic [2:0]    idx;
    logic [RW-1:0] row;
    logic          last;
  } beat_t;

  logic          clk, rst;
  logic          in_valid, in_ready;
  logic [IW-1:0] in_a, in_b;
  logic          out_valid, out_ready;
  logic [OW-1:0] out_t, out_s;
  logic [2:0]    out_idx;
  logic [RW-1:0] out_row;
  logic          out_last;

  logic main_ready, rnd_ready, rand_mode;
  assign out_ready = rand_mode ? rnd_ready : main_ready;

  strassen_preadd_stream #(.W(W), .LANES(LANES), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_t(out_t), .out_s(out_s), .out_idx(out_idx),
    .out_row(out_row), .out_last(out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int    total_cnt  = 0;
  int    passed_cnt = 0;
  beat_t exp_q[$];
  beat_t cap_q[$];
  int    model_row  = 0;
  bit    capture_en = 0;
  bit    b2b_mon    = 0;
  int    bubbles    = 0;
  int    beats_seen = 0;
  int    lasts_seen = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) passed_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Reference: the seven-product operand table in plain integer arithmetic.
  function automatic beat_t model_beat(input logic [IW-1:0] a, input logic [IW-1:0] b,
                                       input int k, input int r);
    beat_t bt;
    int ea[4], eb[4];
    int tv, sv;
    bt = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int q = 0; q < 4; q++) begin
        ea[q] = int'($signed(a[q*QW + i*W +: W]));
        eb[q] = int'($signed(b[q*QW + i*W +: W]));
      end
      case (k)
        1: begin tv = ea[0] + ea[3]; sv = eb[0] + eb[3]; end
        2: begin tv = ea[2] + ea[3]; sv = eb[0];         end
        3: begin tv = ea[0];         sv = eb[1] - eb[3]; end
        4: begin tv = ea[3];         sv = eb[2] - eb[0]; end
        5: begin tv = ea[0] + ea[1]; sv = eb[3];         end
        6: begin tv = ea[2] - ea[0]; sv = eb[0] + eb[1]; end
        default: begin tv = ea[1] - ea[3]; sv = eb[2] + eb[3]; end
      endcase
      bt.t[i*(W+1) +: W+1] = tv[W:0];
      bt.s[i*(W+1) +: W+1] = sv[W:0];
    end
    bt.idx  = k[2:0];
    bt.row  = r[RW-1:0];
    bt.last = (k == 7) && (r == ROWS - 1);
    return bt;
  endfunction

  function automatic beat_t dut_beat();
    beat_t bt;
    bt.t = out_t; bt.s = out_s; bt.idx = out_idx; bt.row = out_row; bt.last = out_last;
    return bt;
  endfunction

  // Monitor: compare every accepted output beat against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      beat_t got, e;
      got = dut_beat();
      if (exp_q.size() == 0) begin
        check("spurious_beat", 256'(got), 256'(0));
      end else begin
        e = exp_q.pop_front();
        check($sformatf("beat k%0d row%0d", e.idx, e.row), 256'(got), 256'(e));
      end
      beats_seen++;
      if (got.last) lasts_seen++;
      if (capture_en) cap_q.push_back(got);
    end
  end

  // Bubble detector for the back-to-back stream.
  always @(negedge clk) begin
    if (b2b_mon && !out_valid) bubbles++;
  end

  // Random downstream backpressure.
  initial begin
    rnd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 rnd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [IW-1:0] rand_row();
    logic [IW-1:0] v;
    for (int i = 0; i < IW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic send_row(input logic [IW-1:0] a, input logic [IW-1:0] b);
    bit done;
    done     = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        for (int k = 1; k <= 7; k++) exp_q.push_back(model_beat(a, b, k, model_row));
        model_row = (model_row + 1) % ROWS;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 256'(0), 256'(1));
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(posedge clk);
      if (exp_q.size() == 0) done = 1;
    end
    #1;
    if (!done) check("drain_timeout", 256'(exp_q.size()), 256'(0));
  endtask

  task automatic wait_beat(input int k, input int r, input bit any_row);
    bit done;
    done = 0;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      if (out_valid && out_idx == k[2:0] && (any_row || out_row == r[RW-1:0])) done = 1;
    end
    if (!done) check("beat_wait_timeout", 256'(0), 256'(1));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    model_row = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [IW-1:0] a, b;
    int exp_t[7];
    int exp_s[7];
    int beats0, lasts0;
    exp_t = '{-123, -121, 5, -128, 2, 2, 125};
    exp_s = '{131, 127, -3, -129, 4, 128, 2};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    main_ready = 1'b1; rand_mode = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  256'(in_ready),  256'(0));
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_out_t",     256'(out_t),     256'(0));
    check("rst_out_s",     256'(out_s),     256'(0));
    check("rst_out_idx",   256'(out_idx),   256'(1));
    check("rst_out_row",   256'(out_row),   256'(0));
    check("rst_out_last",  256'(out_last),  256'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready",  256'(in_ready),  256'(1));
    check("idle_out_valid", 256'(out_valid), 256'(0));
    @(posedge clk);
    #1;

    // Directed operand table check with fixed element values.
    for (int i = 0; i < LANES; i++) begin
      a[Q11_OFF() + i*W +: W] = 8'd5;   a[QW   + i*W +: W] = 8'hFD;
      a[2*QW + i*W +: W]      = 8'd7;   a[3*QW + i*W +: W] = 8'h80;
      b[Q11_OFF() + i*W +: W] = 8'h7F;  b[QW   + i*W +: W] = 8'd1;
      b[2*QW + i*W +: W]      = 8'hFE;  b[3*QW + i*W +: W] = 8'd4;
    end
    capture_en = 1;
    send_row(a, b);
    @(negedge clk);
    check("first_beat_latency", 256'({out_valid, out_idx}), 256'({1'b1, 3'd1}));
    wait_drain();
    capture_en = 0;
    check("dir_beat_count", 256'(cap_q.size()), 256'(7));
    for (int k = 0; k < 7 && k < cap_q.size(); k++) begin
      check($sformatf("dir_t_k%0d", k + 1), 256'(cap_q[k].t[W:0]), 256'(exp_t[k][W:0]));
      check($sformatf("dir_s_k%0d", k + 1), 256'(cap_q[k].s[W:0]), 256'(exp_s[k][W:0]));
      check($sformatf("dir_t_hi_k%0d", k + 1), 256'(cap_q[k].t[(LANES-1)*(W+1) +: W+1]),
            256'(exp_t[k][W:0]));
    end

    // Backpressure on the k=4 beat.
    send_row(rand_row(), rand_row());
    wait_beat(3, 0, 1);
    @(posedge clk);
    #1 main_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (exp_q.size() > 0)
        check("bp_hold", 256'({out_valid, dut_beat()}), 256'({1'b1, exp_q[0]}));
      else
        check("bp_queue_empty", 256'(0), 256'(1));
      @(posedge clk);
      #1;
    end
    main_ready = 1'b1;
    wait_drain();

    // Back-to-back: nine rows with in_valid kept high.
    do_reset();
    beats0 = beats_seen;
    lasts0 = lasts_seen;
    for (int r = 0; r < 9; r++) begin
      send_row(rand_row(), rand_row());
      if (r == 0) b2b_mon = 1;
    end
    b2b_mon = 0;
    wait_drain();
    check("b2b_bubbles", 256'(bubbles), 256'(0));
    check("b2b_beats",   256'(beats_seen - beats0), 256'(63));
    check("b2b_lasts",   256'(lasts_seen - lasts0), 256'(1));

    // Input starvation returns to IDLE.
    send_row(rand_row(), rand_row());
    wait_drain();
    @(negedge clk);
    check("starve_out_valid", 256'(out_valid), 256'(0));
    check("starve_in_ready",  256'(in_ready),  256'(1));
    @(posedge clk);
    #1;

    // Reset during k=3 of row 2.
    do_reset();
    for (int r = 0; r < 3; r++) send_row(rand_row(), rand_row());
    wait_beat(2, 2, 0);
    @(posedge clk);
    #1 main_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_beat", 256'({out_valid, out_idx, out_row}), 256'({1'b1, 3'd3, 3'd2}));
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    model_row = 0;
    @(negedge clk);
    check("midrst_out_valid", 256'(out_valid), 256'(0));
    check("midrst_in_ready",  256'(in_ready),  256'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    main_ready = 1'b1;
    @(negedge clk);
    check("postrst_out_valid", 256'(out_valid), 256'(0));
    @(posedge clk);
    #1;
    send_row(rand_row(), rand_row());
    @(negedge clk);
    check("postrst_first", 256'({out_valid, out_idx, out_row}), 256'({1'b1, 3'd1, 3'd0}));
    wait_drain();

    // Random traffic with random gaps and backpressure.
    rand_mode = 1'b1;
    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send_row(rand_row(), rand_row());
    end
    wait_drain();
    rand_mode = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
    $finish;
  end

  function automatic int Q11_OFF();
    return 0;
  endfunction

endmodule
